// File: rtl/fibo_seq_ctrl.sv
// Sequencer for a 4-bit Fibonacci generator. It clears the generator, steps it once per
// accepted term, and streams each term with its index over a valid/ready port.
module fibo_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             gen_clr,
  output logic             gen_step,
  input  logic [WIDTH-1:0] gen_value,
  output logic [WIDTH-1:0] term_out,
  output logic [CNT_W-1:0] term_idx,
  output logic             term_valid,
  input  logic             term_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_CAPTURE,
    S_OUTPUT,
    S_STEP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             clr_q, clr_d;
  logic             step_q, step_d;
  logic             valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    term_d  = term_q;
    prev_d  = prev_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_terms != '0) begin
            state_d = S_CLEAR;
            count_d = num_terms;
            idx_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_CLEAR: state_d = S_CAPTURE;
      S_CAPTURE: begin
        term_d = gen_value;
        prev_d = gen_value;
        // A term smaller than its predecessor can only come from a modular wrap.
        if ((idx_q >= CNT_W'(2)) && (gen_value < prev_q)) begin
          ovf_d = 1'b1;
        end
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (term_ready) begin
          if (idx_q == count_q - CNT_W'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_STEP;
            idx_d   = idx_q + CNT_W'(1);
          end
        end
      end
      S_STEP:  state_d = S_CAPTURE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs are registered copies of the next-state decode, so they
  // track the state register exactly while staying glitch-free.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    clr_d   = (state_d == S_CLEAR);
    step_d  = (state_d == S_STEP);
    valid_d = (state_d == S_OUTPUT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      term_q  <= '0;
      prev_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      step_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      term_q  <= term_d;
      prev_q  <= prev_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
      step_q  <= step_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    busy       = busy_q;
    done       = done_q;
    ovf        = ovf_q;
    gen_clr    = clr_q;
    gen_step   = step_q;
    term_out   = term_q;
    term_idx   = idx_q;
    term_valid = valid_q;
  end

endmodule

// File: tb/tb_fibo_seq_ctrl.sv
// Scoreboard bench for fibo_seq_ctrl with a behavioural Fibonacci generator attached.
module tb_fibo_seq_ctrl;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_terms = '0;
  logic             busy, done, ovf, gen_clr, gen_step, term_valid;
  logic [WIDTH-1:0] gen_value, term_out;
  logic [CNT_W-1:0] term_idx;
  logic             term_ready = 1'b1;

  fibo_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_terms(num_terms),
    .busy(busy), .done(done), .ovf(ovf), .gen_clr(gen_clr), .gen_step(gen_step),
    .gen_value(gen_value), .term_out(term_out), .term_idx(term_idx),
    .term_valid(term_valid), .term_ready(term_ready)
  );

  always #5 clk = ~clk;

  // Generator: clear to 0, step to next term modulo 2**WIDTH.
  logic [WIDTH-1:0] gen_a = '0, gen_b = '0;
  always @(posedge clk) begin
    if (gen_clr) begin
      gen_a <= '0;
      gen_b <= WIDTH'(1);
    end else if (gen_step) begin
      gen_a <= gen_b;
      gen_b <= gen_a + gen_b;
    end
  end
  assign gen_value = gen_a;

  typedef struct {
    logic [WIDTH-1:0] term;
    logic [CNT_W-1:0] idx;
    logic             ovf;
    logic             last;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: true Fibonacci number; the emitted term is it modulo 2**WIDTH and
  // the sticky wrap flag is set once the true value no longer fits.
  function automatic int unsigned fib_true(input int unsigned k);
    int unsigned a = 0, b = 1, t;
    repeat (k) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic push_run(input int unsigned n);
    exp_t e;
    for (int unsigned k = 0; k < n; k++) begin
      e.term = WIDTH'(fib_true(k) % (1 << WIDTH));
      e.idx  = CNT_W'(k);
      e.ovf  = (fib_true(k) >= (1 << WIDTH));
      e.last = (k == n - 1);
      sb.push_back(e);
    end
  endtask

  // Ready driver: constant high, random, or a stall on one index.
  int ready_mode = 0;
  int hold_idx = 0, stall_len = 0, stall_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (ready_mode == 2 && term_valid && term_idx == CNT_W'(hold_idx) && stall_cnt < stall_len) begin
      term_ready = 1'b0;
      stall_cnt++;
    end else begin
      term_ready = (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (ready_mode != 2) stall_cnt = 0;
    end
  end

  // Monitor
  logic             zero_pending = 1'b0;
  logic             done_due = 1'b0;
  logic             held_v = 1'b0;
  logic [WIDTH-1:0] held_t;
  logic [CNT_W-1:0] held_i;
  int               step_cnt = 0, clr_cnt = 0;
  exp_t             got;

  always @(negedge clk) begin
    if (gen_step) step_cnt++;
    if (gen_clr) clr_cnt++;
    if (done || done_due || zero_pending) chk("done_pulse", done, done_due || zero_pending);
    done_due = 1'b0;
    if (term_valid) begin
      if (held_v) begin
        chk("hold_term", term_out, held_t);
        chk("hold_idx", term_idx, held_i);
        chk("no_step_stalled", gen_step, 0);
      end
      if (term_ready) begin
        held_v = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_term: got idx %0d term %0d, expected no term", term_idx, term_out);
        end else begin
          got = sb.pop_front();
          chk("term", term_out, got.term);
          chk("idx", term_idx, got.idx);
          chk("ovf", ovf, got.ovf);
          done_due = got.last;
        end
      end else begin
        held_v = 1'b1;
        held_t = term_out;
        held_i = term_idx;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  int step0, clr0;

  task automatic do_start(input int unsigned n);
    int unsigned w = 0;
    @(negedge clk);
    while (busy && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("idle_before_start", busy, 0);
    if (n != 0) push_run(n);
    step0 = step_cnt;
    clr0  = clr_cnt;
    start = 1'b1;
    num_terms = CNT_W'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    num_terms = CNT_W'($urandom);
    if (n == 0) zero_pending = 1'b1;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("gen_clr_latency", gen_clr, n != 0);
    if (n == 0) begin
      #1 zero_pending = 1'b0;
    end else begin
      @(negedge clk);
      chk("valid_not_early", term_valid, 0);
      @(negedge clk);
      chk("first_valid_latency", term_valid, 1);
    end
  endtask

  task automatic finish_run(input int unsigned n);
    int unsigned w = 0;
    while (busy && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("run_ends", busy, 0);
    chk("sb_empty", sb.size(), 0);
    chk("gen_step_count", step_cnt - step0, (n == 0) ? 0 : n - 1);
    chk("gen_clr_count", clr_cnt - clr0, (n == 0) ? 0 : 1);
  endtask

  task automatic check_reset_state();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_gen_clr", gen_clr, 0);
    chk("rst_gen_step", gen_step, 0);
    chk("rst_valid", term_valid, 0);
    chk("rst_term", term_out, 0);
    chk("rst_idx", term_idx, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    reset = 1'b1;

    // Basic run
    ready_mode = 0;
    do_start(5);
    finish_run(5);
    chk("ovf_clear_n5", ovf, 0);

    // Wrap at idx 8, sticky after done
    do_start(10);
    finish_run(10);
    chk("ovf_sticky_n10", ovf, 1);

    // Backpressure on idx 2; new start clears ovf
    ready_mode = 2; hold_idx = 2; stall_len = 4;
    do_start(4);
    finish_run(4);
    chk("ovf_cleared_n4", ovf, 0);
    ready_mode = 0;

    // Zero-length run
    do_start(0);
    finish_run(0);

    // Reset in the middle of a run
    ready_mode = 2; hold_idx = 3; stall_len = 1000;
    do_start(8);
    w = 0;
    while (!(term_valid && term_idx == CNT_W'(3)) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("reach_idx3", term_valid && term_idx == CNT_W'(3), 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    ready_mode = 0;
    @(negedge clk);
    check_reset_state();
    do_start(3);
    finish_run(3);
    chk("ovf_after_reset_run", ovf, 0);

    // Start while busy is ignored
    do_start(6);
    repeat (4) @(negedge clk);
    start = 1'b1;
    num_terms = CNT_W'(2);
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_run(6);

    // Randomized runs with random backpressure
    ready_mode = 1;
    for (int i = 0; i < 10; i++) begin
      n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
      do_start(n);
      finish_run(n);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
